// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: groups the CPU/IOP request ports, the main-memory port
// and the arbiter status flags of memory_arbiter into one bundle.
//
// Handshake: a requester raises <x>_req with <x>_we/<x>_addr/<x>_wdata stable
// and holds it until it sees <x>_ack high for one cycle, then drops req on the
// following clock edge. A req still high when the arbiter is back in IDLE is a
// new access. Dropping req before ack while the access is running abandons it.
// Read data on <x>_rdata is valid in the cycle <x>_ack is high.
//
// modport slave  : the arbiter's view.
// modport master : the view of whatever drives the requesters and models memory.
interface memory_arbiter_if #(
  parameter int ADDR_W = 17
) ();

  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;

  // IOP requester
  logic              iop_req;
  logic              iop_we;
  logic [ADDR_W-1:0] iop_addr;
  logic [31:0]       iop_wdata;
  logic              iop_ack;
  logic [31:0]       iop_rdata;

  // Single-port main memory
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_en;
  logic [31:0]       mem_data_out;
  logic [31:0]       mem_data_in;

  // Status
  logic              busy;
  logic              abort;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  iop_req, iop_we, iop_addr, iop_wdata,
    output iop_ack, iop_rdata,
    output mem_address, mem_write_en, mem_data_out,
    input  mem_data_in,
    output busy, abort
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output iop_req, iop_we, iop_addr, iop_wdata,
    input  iop_ack, iop_rdata,
    input  mem_address, mem_write_en, mem_data_out,
    output mem_data_in,
    input  busy, abort
  );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port 32-bit main memory between the CPU
// and the IOP. Every access is sequenced IDLE -> ACCESS (WAIT_STATES+1 cycles)
// -> DONE (one-cycle ack). The owner dropping its req during ACCESS abandons
// the access: no write, no ack, one-cycle abort pulse.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, CPU wins simultaneous requests.
//   defined   : a last_owner flop (reset to IOP) gives a tie to whichever
//               requester was not served last; updated on every DONE.
//
// dbg_state exposes the FSM state encoding (0 IDLE, 1 ACCESS, 2 DONE).
module memory_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 17
) (
  input  logic              clock,
  input  logic              reset,
  memory_arbiter_if.slave   bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic       OWNER_CPU = 1'b0;
  localparam logic       OWNER_IOP = 1'b1;
  localparam logic [3:0] WS_INIT   = 4'(WAIT_STATES);

  // FSM and latched access
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;

  // Per-requester read data holding registers
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       iop_rdata_q, iop_rdata_d;

  // Registered one-cycle abort pulse, visible in the cycle after abandonment
  logic              abort_q, abort_d;

  // Arbitration result and helper terms
  logic              grant_iop;
  logic              owner_req;
  logic              any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_owner_q, last_owner_d;

  // Tie goes to the requester that was not served last
  always_comb begin
    grant_iop = bus.iop_req && (!bus.cpu_req || (last_owner_q == OWNER_CPU));
  end
`else
  // Fixed priority: IOP only wins when the CPU is not asking
  always_comb begin
    grant_iop = bus.iop_req && !bus.cpu_req;
  end
`endif

  // Current owner's request line, used to detect abandonment during ACCESS
  always_comb begin
    any_req   = bus.cpu_req || bus.iop_req;
    owner_req = (owner_q == OWNER_IOP) ? bus.iop_req : bus.cpu_req;
  end

  // Next-state, datapath latching and the combinational strobes
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    iop_rdata_d  = iop_rdata_q;
    abort_d      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    bus.mem_write_en = 1'b0;
    bus.cpu_ack      = 1'b0;
    bus.iop_ack      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = grant_iop ? OWNER_IOP : OWNER_CPU;
          we_d    = grant_iop ? bus.iop_we    : bus.cpu_we;
          addr_d  = grant_iop ? bus.iop_addr  : bus.cpu_addr;
          wdata_d = grant_iop ? bus.iop_wdata : bus.cpu_wdata;
          cnt_d   = WS_INIT;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (!owner_req) begin
          // Abandoned: write enable stays low even in the final cycle
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final ACCESS cycle: memory writes on the coming edge, or read
          // data is captured on it into the owner's holding register
          bus.mem_write_en = we_q;
          if (!we_q) begin
            if (owner_q == OWNER_IOP) begin
              iop_rdata_d = bus.mem_data_in;
            end else begin
              cpu_rdata_d = bus.mem_data_in;
            end
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        bus.cpu_ack = (owner_q == OWNER_CPU);
        bus.iop_ack = (owner_q == OWNER_IOP);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      cpu_rdata_q  <= '0;
      iop_rdata_q  <= '0;
      abort_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWNER_IOP;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      iop_rdata_q  <= iop_rdata_d;
      abort_q      <= abort_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Registered outputs; the memory port shows the latched access values
  always_comb begin
    bus.mem_address  = addr_q;
    bus.mem_data_out = wdata_q;
    bus.cpu_rdata    = cpu_rdata_q;
    bus.iop_rdata    = iop_rdata_q;
    bus.busy         = (state_q != ST_IDLE);
    bus.abort        = abort_q;
    dbg_state        = state_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench for memory_arbiter. Instance A runs with
// WAIT_STATES=0, instance B with WAIT_STATES=3; each has its own word memory
// model with a preload port.
module tb_memory_arbiter;

  localparam int AW = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  memory_arbiter_if #(.ADDR_W(AW)) bus_a ();
  memory_arbiter_if #(.ADDR_W(AW)) bus_b ();
  logic [1:0] state_a;
  logic [1:0] state_b;

  memory_arbiter #(.WAIT_STATES(0), .ADDR_W(AW)) dut_a (
    .clock(clk), .reset(rst_a), .bus(bus_a), .dbg_state(state_a)
  );
  memory_arbiter #(.WAIT_STATES(3), .ADDR_W(AW)) dut_b (
    .clock(clk), .reset(rst_b), .bus(bus_b), .dbg_state(state_b)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic        pre_we_a;
  logic        pre_we_b;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we_a) mem_a[pre_addr] <= pre_data;
    else if (bus_a.mem_write_en) mem_a[bus_a.mem_address[7:0]] <= bus_a.mem_data_out;
  end
  always @(posedge clk) begin
    if (pre_we_b) mem_b[pre_addr] <= pre_data;
    else if (bus_b.mem_write_en) mem_b[bus_b.mem_address[7:0]] <= bus_b.mem_data_out;
  end
  assign bus_a.mem_data_in = mem_a[bus_a.mem_address[7:0]];
  assign bus_b.mem_data_in = mem_b[bus_b.mem_address[7:0]];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit inst, input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    if (inst) pre_we_b = 1'b1; else pre_we_a = 1'b1;
    tick();
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  task automatic start_req(input bit inst, input bit iop, input bit we,
                           input logic [AW-1:0] addr, input logic [31:0] wd);
    if (!inst && !iop) begin
      bus_a.cpu_we = we; bus_a.cpu_addr = addr; bus_a.cpu_wdata = wd; bus_a.cpu_req = 1'b1;
    end else if (!inst) begin
      bus_a.iop_we = we; bus_a.iop_addr = addr; bus_a.iop_wdata = wd; bus_a.iop_req = 1'b1;
    end else if (!iop) begin
      bus_b.cpu_we = we; bus_b.cpu_addr = addr; bus_b.cpu_wdata = wd; bus_b.cpu_req = 1'b1;
    end else begin
      bus_b.iop_we = we; bus_b.iop_addr = addr; bus_b.iop_wdata = wd; bus_b.iop_req = 1'b1;
    end
  endtask

  task automatic drop_req(input bit inst, input bit iop);
    if (!inst && !iop) bus_a.cpu_req = 1'b0;
    else if (!inst)    bus_a.iop_req = 1'b0;
    else if (!iop)     bus_b.cpu_req = 1'b0;
    else               bus_b.iop_req = 1'b0;
  endtask

  function automatic logic get_ack(input bit inst, input bit iop);
    if (!inst) return iop ? bus_a.iop_ack : bus_a.cpu_ack;
    return iop ? bus_b.iop_ack : bus_b.cpu_ack;
  endfunction

  function automatic logic [31:0] get_rdata(input bit inst, input bit iop);
    if (!inst) return iop ? bus_a.iop_rdata : bus_a.cpu_rdata;
    return iop ? bus_b.iop_rdata : bus_b.cpu_rdata;
  endfunction

  function automatic logic get_busy(input bit inst);
    return inst ? bus_b.busy : bus_a.busy;
  endfunction

  function automatic logic get_wen(input bit inst);
    return inst ? bus_b.mem_write_en : bus_a.mem_write_en;
  endfunction

  // One complete access: latency counted in cycles from raising req to ack
  task automatic access(input bit inst, input bit iop, input bit we,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        output int lat, output int busy_n, output int wen_n,
                        output logic [31:0] rd);
    lat = 0; busy_n = 0; wen_n = 0; rd = '0;
    start_req(inst, iop, we, addr, wd);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (get_busy(inst)) busy_n++;
      if (get_wen(inst)) wen_n++;
      if (get_ack(inst, iop)) begin
        lat = i;
        rd  = get_rdata(inst, iop);
        break;
      end
    end
    drop_req(inst, iop);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"},  bus_a.busy, 1'b0);
    check({tag, "_cack"},  bus_a.cpu_ack, 1'b0);
    check({tag, "_iack"},  bus_a.iop_ack, 1'b0);
    check({tag, "_wen"},   bus_a.mem_write_en, 1'b0);
    check({tag, "_abort"}, bus_a.abort, 1'b0);
    check({tag, "_crd"},   bus_a.cpu_rdata, 32'h0);
    check({tag, "_ird"},   bus_a.iop_rdata, 32'h0);
    check({tag, "_addr"},  bus_a.mem_address, 17'h0);
    check({tag, "_dout"},  bus_a.mem_data_out, 32'h0);
    check({tag, "_state"}, state_a, 2'd0);
  endtask

  task automatic check_reset_b(input string tag);
    check({tag, "_busy"},  bus_b.busy, 1'b0);
    check({tag, "_cack"},  bus_b.cpu_ack, 1'b0);
    check({tag, "_iack"},  bus_b.iop_ack, 1'b0);
    check({tag, "_wen"},   bus_b.mem_write_en, 1'b0);
    check({tag, "_abort"}, bus_b.abort, 1'b0);
    check({tag, "_crd"},   bus_b.cpu_rdata, 32'h0);
    check({tag, "_ird"},   bus_b.iop_rdata, 32'h0);
    check({tag, "_addr"},  bus_b.mem_address, 17'h0);
    check({tag, "_dout"},  bus_b.mem_data_out, 32'h0);
    check({tag, "_state"}, state_b, 2'd0);
  endtask

  // ---------------- directed sequence ----------------
  int lat, bn, wn, cpu_n, iop_n, cack_n;
  logic [31:0] rd;
  logic [0:0] exp_owner;
  logic [31:0] sh [0:7];
  bit act [0:1];
  bit rwe [0:1];
  logic [2:0] radr [0:1];
  logic [31:0] rdat [0:1];
  int issued [0:1];
  int acked [0:1];
  logic wen_legal;

  initial begin
    bus_a.cpu_req = 0; bus_a.cpu_we = 0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
    bus_a.iop_req = 0; bus_a.iop_we = 0; bus_a.iop_addr = '0; bus_a.iop_wdata = '0;
    bus_b.cpu_req = 0; bus_b.cpu_we = 0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
    bus_b.iop_req = 0; bus_b.iop_we = 0; bus_b.iop_addr = '0; bus_b.iop_wdata = '0;
    pre_we_a = 0; pre_we_b = 0; pre_addr = '0; pre_data = '0;
    rst_a = 1; rst_b = 1;

    preload(0, 8'h10, 32'h0);
    preload(0, 8'h20, 32'h0);
    preload(0, 8'h40, 32'h0BADF00D);
    for (int i = 0; i < 8; i++) begin
      sh[i] = 32'h1000_0000 + 32'(i);
      preload(0, 8'h60 + 8'(i), sh[i]);
    end
    preload(1, 8'h05, 32'h12345678);
    preload(1, 8'h30, 32'h11111111);
    preload(1, 8'h50, 32'h22222222);
    tick();
    check_reset_a("rst_a");
    check_reset_b("rst_b");
    rst_a = 0; rst_b = 0;
    tick();

    // Test 1: WAIT_STATES=0 CPU write then read, IOP write then read
    access(0, 0, 1, 17'h10, 32'hDEADBEEF, lat, bn, wn, rd);
    check("t1_wr_lat", lat, 2);
    check("t1_wr_wen_cycles", wn, 1);
    check("t1_wr_busy_cycles", bn, 2);
    check("t1_wr_mem", mem_a[8'h10], 32'hDEADBEEF);
    tick();
    check("t1_idle_busy", bus_a.busy, 1'b0);
    access(0, 0, 0, 17'h10, 32'h0, lat, bn, wn, rd);
    check("t1_rd_lat", lat, 2);
    check("t1_rd_wen_cycles", wn, 0);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_iop_rdata_kept", bus_a.iop_rdata, 32'h0);
    tick();
    access(0, 1, 1, 17'h20, 32'hCAFEF00D, lat, bn, wn, rd);
    check("t1_iwr_lat", lat, 2);
    check("t1_iwr_mem", mem_a[8'h20], 32'hCAFEF00D);
    tick();
    access(0, 1, 0, 17'h20, 32'h0, lat, bn, wn, rd);
    check("t1_ird_data", rd, 32'hCAFEF00D);
    check("t1_ird_cpu_rdata_kept", bus_a.cpu_rdata, 32'hDEADBEEF);
    tick();

    // Test 2: WAIT_STATES=3 IOP read
    access(1, 1, 0, 17'h05, 32'h0, lat, bn, wn, rd);
    check("t2_lat", lat, 5);
    check("t2_busy_cycles", bn, 5);
    check("t2_wen_cycles", wn, 0);
    check("t2_data", rd, 32'h12345678);
    tick();
    check("t2_idle_busy", bus_b.busy, 1'b0);

    // Test 3: simultaneous back-to-back requests, four each
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin exp_q.push_back(1'b0); exp_q.push_back(1'b1); end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
`endif
    cpu_n = 0; iop_n = 0;
    start_req(0, 0, 0, 17'h10, 32'h0);
    start_req(0, 1, 0, 17'h20, 32'h0);
    for (int i = 0; i < 60 && (cpu_n < 4 || iop_n < 4); i++) begin
      tick();
      check("t3_ack_excl", bus_a.cpu_ack & bus_a.iop_ack, 1'b0);
      if (bus_a.cpu_ack || bus_a.iop_ack) begin
        if (exp_q.size() > 0) exp_owner = exp_q.pop_front();
        else exp_owner = 1'bx;
        check("t3_order", bus_a.iop_ack, exp_owner);
      end
      if (bus_a.cpu_ack) begin
        check("t3_cpu_rdata", bus_a.cpu_rdata, 32'hDEADBEEF);
        cpu_n++;
        if (cpu_n == 4) drop_req(0, 0);
      end
      if (bus_a.iop_ack) begin
        check("t3_iop_rdata", bus_a.iop_rdata, 32'hCAFEF00D);
        iop_n++;
        if (iop_n == 4) drop_req(0, 1);
      end
    end
    drop_req(0, 0); drop_req(0, 1);
    check("t3_cpu_count", cpu_n, 4);
    check("t3_iop_count", iop_n, 4);
    check("t3_queue_empty", exp_q.size(), 0);
    tick();

    // Test 4: CPU write abandoned mid-ACCESS, pending IOP read served next
    cack_n = 0; wn = 0;
    start_req(1, 0, 1, 17'h30, 32'h55AA55AA);
    tick();
    check("t4_busy", bus_b.busy, 1'b1);
    start_req(1, 1, 0, 17'h05, 32'h0);
    tick();
    check("t4_state_access", state_b, 2'd1);
    drop_req(1, 0);
    tick();
    check("t4_abort", bus_b.abort, 1'b1);
    check("t4_abort_busy", bus_b.busy, 1'b0);
    check("t4_abort_cack", bus_b.cpu_ack, 1'b0);
    tick();
    check("t4_abort_clear", bus_b.abort, 1'b0);
    check("t4_iop_started", bus_b.busy, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_b.cpu_ack) cack_n++;
      if (bus_b.mem_write_en) wn++;
      if (bus_b.iop_ack) begin lat = i; break; end
    end
    check("t4_iop_lat", lat, 4);
    check("t4_iop_rdata", bus_b.iop_rdata, 32'h12345678);
    check("t4_no_cpu_ack", cack_n, 0);
    check("t4_no_write", wn, 0);
    check("t4_mem_kept", mem_b[8'h30], 32'h11111111);
    drop_req(1, 1);
    tick();

    // Test 4b: request falls in the final ACCESS cycle (WAIT_STATES=0)
    start_req(0, 0, 1, 17'h40, 32'h01234567);
    tick();
    check("t4f_wen_final", bus_a.mem_write_en, 1'b1);
    drop_req(0, 0);
    #1;
    check("t4f_wen_forced_low", bus_a.mem_write_en, 1'b0);
    tick();
    check("t4f_abort", bus_a.abort, 1'b1);
    check("t4f_no_ack", bus_a.cpu_ack, 1'b0);
    check("t4f_mem_kept", mem_a[8'h40], 32'h0BADF00D);
    tick();
    check("t4f_abort_clear", bus_a.abort, 1'b0);

    // Test 5: reset during ACCESS of a write
    start_req(1, 0, 1, 17'h50, 32'hA5A5A5A5);
    tick();
    tick();
    check("t5_pre_busy", bus_b.busy, 1'b1);
    rst_b = 1;
    tick();
    check_reset_b("t5_rst");
    rst_b = 0;
    drop_req(1, 0);
    tick();
    tick();
    check("t5_mem_kept", mem_b[8'h50], 32'h22222222);
    access(1, 0, 0, 17'h50, 32'h0, lat, bn, wn, rd);
    check("t5_after_lat", lat, 5);
    check("t5_after_data", rd, 32'h22222222);
    tick();

    // Test 6: random traffic on instance A
    for (int r = 0; r < 2; r++) begin act[r] = 0; issued[r] = 0; acked[r] = 0; end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      check("t6_ack_excl", bus_a.cpu_ack & bus_a.iop_ack, 1'b0);
      if (bus_a.mem_write_en) begin
        wen_legal = 1'b0;
        for (int r = 0; r < 2; r++)
          if (act[r] && rwe[r] && bus_a.mem_address == (17'h60 + 17'(radr[r]))
              && bus_a.mem_data_out == rdat[r]) wen_legal = 1'b1;
        check("t6_wen_owner", wen_legal, 1'b1);
      end
      for (int r = 0; r < 2; r++) begin
        if (get_ack(0, r == 1)) begin
          check("t6_ack_active", act[r], 1'b1);
          acked[r]++;
          if (rwe[r]) begin
            sh[radr[r]] = rdat[r];
            check("t6_wr_mem", mem_a[8'h60 + 8'(radr[r])], rdat[r]);
          end else begin
            check("t6_rd_data", get_rdata(0, r == 1), sh[radr[r]]);
          end
          act[r] = 0;
          drop_req(0, r == 1);
        end else if (!act[r] && cyc < 960 && $urandom_range(0, 2) == 0) begin
          act[r]  = 1;
          rwe[r]  = 1'($urandom_range(0, 1));
          radr[r] = 3'($urandom_range(0, 7));
          rdat[r] = $urandom();
          issued[r]++;
          start_req(0, r == 1, rwe[r], 17'h60 + 17'(radr[r]), rdat[r]);
        end
      end
    end
    check("t6_cpu_all_acked", acked[0], issued[0]);
    check("t6_iop_all_acked", acked[1], issued[1]);
    check("t6_cpu_idle", act[0], 1'b0);
    check("t6_iop_idle", act[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
